// File: rtl/tcp_vlg_pkg.sv
// tcp_vlg_pkg: shared types for the eth_vlg TCP transmit stream buffer
package tcp_vlg_pkg;
  typedef enum logic [1:0] {IDLE, SEND, STALL, FLUSH} tcp_txb_state_t;
  typedef struct packed {
    logic       lst;
    logic [7:0] dat;
  } tcp_txb_ent_t;
endpackage

// File: rtl/tcp_tx_stream_buf_fifo.sv
// tcp_txb_fifo: single-clock byte+last FIFO with registered RAM read into a head register
module tcp_txb_fifo
  import tcp_vlg_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr_en,
  input  tcp_txb_ent_t        wr_ent,
  input  logic                pop,
  output tcp_txb_ent_t        head,
  output logic                head_vld,
  output logic [DEPTH_LOG2:0] count
);
  localparam int N = 1 << DEPTH_LOG2;
  tcp_txb_ent_t mem [N];
  tcp_txb_ent_t head_q;
  logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH_LOG2:0] cnt_q, cnt_d;
  logic vld_q, vld_d, ld;
  // head refills from RAM whenever it is empty or being consumed
  always_comb begin
    ld = (!vld_q | pop) & (cnt_q != '0);
    wp_d = clr ? '0 : wp_q + DEPTH_LOG2'(wr_en);
    rp_d = clr ? '0 : rp_q + DEPTH_LOG2'(ld);
    cnt_d = clr ? '0 : cnt_q + (DEPTH_LOG2+1)'(wr_en) - (DEPTH_LOG2+1)'(ld);
    vld_d = !clr & (ld | (vld_q & !pop));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp_q] <= wr_ent;
    if (ld) head_q <= mem[rp_q];
  end
  assign head = head_q;
  assign head_vld = vld_q;
  assign count = cnt_q + (DEPTH_LOG2+1)'(vld_q);
endmodule

// File: rtl/tcp_tx_stream_buf.sv
// tcp_tx_stream_buf: buffers a user byte stream and feeds the eth_vlg raw TCP input under tcp_cts
module tcp_tx_stream_buf
  import tcp_vlg_pkg::*;
#(
  parameter int DEPTH_LOG2     = 10,
  parameter bit SND_ON_LAST    = 1'b1,
  parameter int IDLE_SND_TICKS = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          s_dat,
  input  logic                s_val,
  input  logic                s_lst,
  output logic                s_rdy,
  input  logic                connected,
  output logic [7:0]          tcp_din,
  output logic                tcp_vin,
  input  logic                tcp_cts,
  output logic                tcp_snd,
  output logic [DEPTH_LOG2:0] level,
  output logic [31:0]         tx_bytes,
  output logic                flushed
);
  tcp_txb_state_t state_q, state_d;
  tcp_txb_ent_t wr_ent, head;
  logic conn_q, conn_p_q, conn_fall;
  logic vin_q, vin_d, lst_q, lst_d, pres_q, pres_d;
  logic snd_q, snd_d, flushed_q, flushed_d, pend_q, pend_d;
  logic [7:0] din_q, din_d;
  logic [31:0] tx_q, tx_d, idle_q, idle_d;
  logic [DEPTH_LOG2:0] fifo_cnt, lvl;
  logic head_vld, pop, wr, xfer;
  tcp_txb_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (conn_fall),
    .wr_en    (wr),
    .wr_ent   (wr_ent),
    .pop      (pop),
    .head     (head),
    .head_vld (head_vld),
    .count    (fifo_cnt)
  );
  // level counts the byte parked in the output register during SEND and STALL
  always_comb begin
    lvl = fifo_cnt + (DEPTH_LOG2+1)'(pres_q);
    s_rdy = conn_q & !lvl[DEPTH_LOG2];
    wr = s_val & s_rdy;
    wr_ent = '{lst: s_lst, dat: s_dat};
    xfer = vin_q & tcp_cts;
    conn_fall = conn_p_q & !conn_q;
  end
  always_comb begin
    state_d = state_q;
    vin_d = vin_q;
    din_d = din_q;
    lst_d = lst_q;
    pres_d = pres_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (conn_q & head_vld) begin
        pop = 1'b1;
        state_d = SEND;
        vin_d = 1'b1;
        pres_d = 1'b1;
        din_d = head.dat;
        lst_d = head.lst;
      end
      SEND: if (!tcp_cts) begin
        state_d = STALL;
        vin_d = 1'b0;
      end else if (head_vld) begin
        pop = 1'b1;
        din_d = head.dat;
        lst_d = head.lst;
      end else begin
        state_d = IDLE;
        vin_d = 1'b0;
        pres_d = 1'b0;
      end
      STALL: if (tcp_cts) begin
        state_d = SEND;
        vin_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (conn_fall) begin
      state_d = FLUSH;
      vin_d = 1'b0;
      pres_d = 1'b0;
      pop = 1'b0;
    end
  end
  // idle timer only arms once something went out since the previous force-send
  always_comb begin
    tx_d = tx_q + 32'(xfer);
    idle_d = (wr | !pend_q | lvl != '0 | IDLE_SND_TICKS == 0) ? '0 : idle_q + 32'd1;
    snd_d = (SND_ON_LAST & xfer & lst_q) | (IDLE_SND_TICKS != 0 && idle_d == 32'(IDLE_SND_TICKS));
    pend_d = !conn_fall & !snd_d & (pend_q | xfer);
    flushed_d = conn_fall & (lvl != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      conn_q <= 1'b0;
      conn_p_q <= 1'b0;
      vin_q <= 1'b0;
      din_q <= '0;
      lst_q <= 1'b0;
      pres_q <= 1'b0;
      snd_q <= 1'b0;
      flushed_q <= 1'b0;
      pend_q <= 1'b0;
      tx_q <= '0;
      idle_q <= '0;
    end else begin
      state_q <= state_d;
      conn_q <= connected;
      conn_p_q <= conn_q;
      vin_q <= vin_d;
      din_q <= din_d;
      lst_q <= lst_d;
      pres_q <= pres_d;
      snd_q <= snd_d;
      flushed_q <= flushed_d;
      pend_q <= pend_d;
      tx_q <= tx_d;
      idle_q <= idle_d;
    end
  end
  assign tcp_vin = vin_q;
  assign tcp_din = din_q;
  assign tcp_snd = snd_q;
  assign flushed = flushed_q;
  assign level = lvl;
  assign tx_bytes = tx_q;
endmodule

// File: doc/tcp_tx_stream_buf.md
# tcp_tx_stream_buf

User-side transmit adapter sitting directly upstream of the raw TCP input of `eth_vlg` (`tcp_din`/`tcp_vin`/`tcp_cts`/`tcp_snd`). It accepts a valid/ready byte stream with an end-of-message marker, buffers it in a FIFO and presents it to the core while obeying the `tcp_cts` back-pressure rule. It replays any byte not accepted by the core and pulses `tcp_snd` at message boundaries or after idle time. It discards buffered data when the connection drops.

## Interface
- `DEPTH_LOG2`, 10: FIFO depth is 2^DEPTH_LOG2 entries of 9 bits (data + last).
- `SND_ON_LAST`, 1: pulse `tcp_snd` after a byte tagged last is transferred.
- `IDLE_SND_TICKS`, 0: pulse `tcp_snd` after this many empty cycles following a transfer; 0 disables.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_dat` in 8: user byte.
- `s_val` in 1: user byte valid.
- `s_lst` in 1: byte ends a message.
- `s_rdy` out 1: block accepts the byte; write occurs when `s_val & s_rdy`.
- `connected` in 1: from `eth_vlg.connected`.
- `tcp_din` out 8: byte to the core.
- `tcp_vin` out 1: byte valid to the core.
- `tcp_cts` in 1: core clear-to-send.
- `tcp_snd` out 1: one-cycle force-send pulse.
- `level` out DEPTH_LOG2+1: FIFO occupancy, including the presented byte.
- `tx_bytes` out 32: bytes transferred since reset; wraps modulo 2^32.
- `flushed` out 1: one-cycle pulse when buffered data was discarded.

## Operation
- Transfer definition: a byte is delivered only on an edge where `tcp_vin & tcp_cts`. The FIFO pops only then, `tx_bytes` increments, and the head advances.
- `s_rdy = conn_q & !full`, where `conn_q` is `connected` registered by one cycle. Writes while `!conn_q` are impossible.
- State machine, with every output registered:
  - IDLE: `tcp_vin`=0. Goes to SEND when the FIFO is non-empty and `conn_q`.
  - SEND: `tcp_vin`=1 and `tcp_din` = head.
    - On a transfer, load the next head. If none remains, go to IDLE.
    - If `tcp_cts`=0, go to STALL and deassert `tcp_vin` on the next edge. This satisfies the one-tick rule.
    - A byte presented while `tcp_cts`=0 is not consumed and is re-presented later.
  - STALL: `tcp_vin`=0 and the head is held. Return to SEND the cycle after `tcp_cts`=1 is sampled.
  - FLUSH: entered from any state when `conn_q` falls.
    - Clears FIFO pointers, pulses `flushed` only if `level`≠0, and drops `tcp_vin`.
    - Goes to IDLE the next cycle.
- `tcp_snd` pulses for one cycle in either case:
  - the edge after a transfer of a byte with last=1, when SND_ON_LAST=1;
  - when the idle counter reaches IDLE_SND_TICKS. The counter runs only while the FIFO is empty and bytes have been transferred since the last `tcp_snd`; any write resets it.
- Full: `s_rdy`=0, with no overflow. A pop and a write in the same cycle keep `level` unchanged.
- Simultaneous disconnect and transfer: the disconnect wins. The byte counts as transferred and the FIFO is still cleared.

## Timing
- Reset values:
  - `s_rdy`=0, `tcp_vin`=0, `tcp_din`=0, `tcp_snd`=0, `flushed`=0.
  - `level`=0, `tx_bytes`=0, state IDLE.
- Latency: a write into an empty FIFO at edge N gives `tcp_vin`=1 after edge N+2 (registered RAM read, then output register).
- Sustained throughput is 1 byte/cycle while `tcp_cts`=1.
- `tcp_cts` falling seen at edge N gives `tcp_vin`=0 after edge N+1.
- `tcp_cts` rising seen at edge M gives `tcp_vin`=1 after edge M+1, with the same byte.
- `tcp_snd` occurs 1 cycle after the last-byte transfer.
- `connected` falling gives `s_rdy`=0 after 1 cycle and the FIFO cleared after 2 cycles.
- `rst` mid-transfer: all state is cleared and no `tcp_snd` or `flushed` pulse is produced.

## Structure
- State enum `tcp_txb_state_t` (IDLE, SEND, STALL, FLUSH) goes in `tcp_vlg_pkg`.
- Sub-module `tcp_txb_fifo`: single-clock, 9-bit-wide, 2^DEPTH_LOG2 deep, registered read, with synchronous `clr` and an occupancy output.
- The FSM, snd logic and counters live in the top module.

## Test plan
- `connected`=1, `tcp_cts`=1, write 16 bytes 0x00..0x0F with last on 0x0F -> `tcp_din` 0x00..0x0F on consecutive cycles, `tx_bytes`=16, one `tcp_snd` pulse one cycle after 0x0F.
- `tcp_cts` low for 5 cycles while 0x42 is presented -> `tcp_vin` drops the next cycle, 0x42 is re-presented and counted once, with no loss or duplication.
- Fill 1024 bytes with `tcp_cts`=0 -> `s_rdy`=0 and `level`=1024. Release cts -> all 1024 bytes are transferred in order.
- Drop `connected` with 100 bytes buffered -> `flushed` pulses once, `level`=0, `tcp_vin`=0, `tx_bytes` unchanged.
- IDLE_SND_TICKS=8, send 3 bytes without last -> one `tcp_snd` 8 cycles after the FIFO empties, and no repeat.
- Assert `rst` mid-stream -> all outputs at reset values on the next cycle.
